// File: rtl/intra_4x4_mode_sched.sv
// Intra 4x4 mode scheduler: issues candidate modes per block, picks the cheapest SATD+lambda cost,
// and accumulates the macroblock cost. Define I4X4_FAST_MODE_EN to limit candidates to modes 0..2.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

module intra_4x4_mode_sched #(
    parameter int SATD_LAT = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      top_avail_i,
    input  logic                      left_avail_i,
    input  logic [6:0]                lambda_i,
    input  logic [3:0]                pred_mode_i,
    input  logic [`BIT_DEPTH+7:0]     satd_i,
    input  logic                      rec_done_i,
    output logic [3:0]                blk_num_o,
    output logic [3:0]                mode_o,
    output logic                      mode_val_o,
    output logic                      min_val_o,
    output logic [3:0]                min_mode_o,
    output logic [3:0]                min_num_o,
    output logic [`BIT_DEPTH+11:0]    cost_o,
    output logic                      done_o
);
    localparam int CW = `BIT_DEPTH + 9;
    localparam int TW = `BIT_DEPTH + 12;

    typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, DECIDE, WAIT_REC, DONE} state_t;

    state_t              r_state;
    logic [8:0]          r_pend;
    logic [SATD_LAT-1:0] r_tagVal;
    logic [3:0]          r_tagMode [SATD_LAT];
    logic [CW-1:0]       r_min;
    logic [3:0]          r_minModeRun;
    logic                r_haveMin;
    logic [3:0]          r_blk;
    logic [3:0]          r_mode;
    logic                r_modeVal;
    logic                r_minVal;
    logic [3:0]          r_minMode;
    logic [3:0]          r_minNum;
    logic [TW-1:0]       r_cost;
    logic                r_done;

    logic                w_tagVal;
    logic [3:0]          w_tagMode;
    logic [CW-1:0]       w_cost;
    logic                w_take;
    logic [CW-1:0]       w_minNext;
    logic [3:0]          w_minModeNext;
    logic                w_othersPend;
    logic [3:0]          w_pick;
    logic [8:0]          w_pendRest;
    logic [TW:0]         w_costSum;
    logic [3:0]          w_blkInc;

    // Blocks off the MB edge always see reconstructed neighbours inside the MB.
    function automatic logic [8:0] allowedModes(input logic [3:0] blk, input logic top, input logic left);
        logic       topOk;
        logic       leftOk;
        logic [8:0] m;
        topOk  = blk[3] | blk[1] | top;
        leftOk = blk[2] | blk[0] | left;
        m = {leftOk, topOk, {3{topOk & leftOk}}, topOk, 1'b1, leftOk, topOk};
`ifdef I4X4_FAST_MODE_EN
        m = m & 9'b0_0000_0111;
`endif
        return m;
    endfunction

    assign w_tagVal      = r_tagVal[SATD_LAT-1];
    assign w_tagMode     = r_tagMode[SATD_LAT-1];
    assign w_cost        = {1'b0, satd_i} +
                           ((w_tagMode == pred_mode_i) ? '0 : {{(CW-9){1'b0}}, lambda_i, 2'b00});
    assign w_take        = w_tagVal && (!r_haveMin || (w_cost < r_min));
    assign w_minNext     = w_take ? w_cost : r_min;
    assign w_minModeNext = w_take ? w_tagMode : r_minModeRun;
    assign w_costSum     = {1'b0, r_cost} + {{(TW+1-CW){1'b0}}, w_minNext};
    assign w_blkInc      = r_blk + 4'd1;

    always_comb begin
        w_othersPend = r_modeVal;
        for (int i = 0; i < SATD_LAT - 1; i++) w_othersPend = w_othersPend | r_tagVal[i];
    end

    always_comb begin
        w_pick = 4'd0;
        for (int i = 8; i >= 0; i--) if (r_pend[i]) w_pick = 4'(i);
        w_pendRest = r_pend & ~(9'd1 << w_pick);
    end

    // Tag pipeline lines each returning SATD up with the mode that produced it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tagVal <= '0;
            for (int i = 0; i < SATD_LAT; i++) r_tagMode[i] <= 4'd0;
        end else begin
            r_tagVal[0]  <= r_modeVal;
            r_tagMode[0] <= r_mode;
            for (int i = 1; i < SATD_LAT; i++) begin
                r_tagVal[i]  <= r_tagVal[i-1];
                r_tagMode[i] <= r_tagMode[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pend       <= '0;
            r_min        <= '0;
            r_minModeRun <= '0;
            r_haveMin    <= 1'b0;
            r_blk        <= '0;
            r_mode       <= '0;
            r_modeVal    <= 1'b0;
            r_minVal     <= 1'b0;
            r_minMode    <= '0;
            r_minNum     <= '0;
            r_cost       <= '0;
            r_done       <= 1'b0;
        end else begin
            r_modeVal <= 1'b0;
            r_minVal  <= 1'b0;
            r_done    <= 1'b0;
            if (w_tagVal) begin
                r_haveMin    <= 1'b1;
                r_min        <= w_minNext;
                r_minModeRun <= w_minModeNext;
            end
            case (r_state)
                IDLE: if (start_i) begin
                    r_cost    <= '0;
                    r_blk     <= '0;
                    r_pend    <= allowedModes(4'd0, top_avail_i, left_avail_i);
                    r_haveMin <= 1'b0;
                    r_state   <= ISSUE;
                end
                ISSUE: begin
                    r_mode    <= w_pick;
                    r_modeVal <= 1'b1;
                    r_pend    <= w_pendRest;
                    if (w_pendRest == '0) r_state <= DRAIN;
                end
                // The final cost is folded in combinationally so the decision lands the next cycle.
                DRAIN: if (w_tagVal && !w_othersPend) begin
                    r_minVal  <= 1'b1;
                    r_minMode <= w_minModeNext;
                    r_minNum  <= r_blk;
                    r_cost    <= w_costSum[TW] ? '1 : w_costSum[TW-1:0];
                    r_state   <= DECIDE;
                end
                DECIDE: r_state <= WAIT_REC;
                WAIT_REC: if (rec_done_i) begin
                    if (r_blk == 4'd15) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_blk     <= w_blkInc;
                        r_pend    <= allowedModes(w_blkInc, top_avail_i, left_avail_i);
                        r_haveMin <= 1'b0;
                        r_state   <= ISSUE;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign blk_num_o  = r_blk;
    assign mode_o     = r_mode;
    assign mode_val_o = r_modeVal;
    assign min_val_o  = r_minVal;
    assign min_mode_o = r_minMode;
    assign min_num_o  = r_minNum;
    assign cost_o     = r_cost;
    assign done_o     = r_done;

endmodule

// File: tb/tb_intra_4x4_mode_sched.sv
// Self-checking bench for intra_4x4_mode_sched: transaction-level mode/cost model, SATD and
// reconstruction responders, and one per-cycle compare process.
`ifndef BIT_DEPTH
`define BIT_DEPTH 8
`endif

module tb_intra_4x4_mode_sched;
    localparam int SATD_LAT = 2;
    localparam int COST_MAX = (1 << (`BIT_DEPTH + 12)) - 1;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start_i = 1'b0;
    logic                   top_avail_i = 1'b0;
    logic                   left_avail_i = 1'b0;
    logic [6:0]             lambda_i = '0;
    logic [3:0]             pred_mode_i = '0;
    logic [`BIT_DEPTH+7:0]  satd_i;
    logic                   rec_done_i;
    logic [3:0]             blk_num_o;
    logic [3:0]             mode_o;
    logic                   mode_val_o;
    logic                   min_val_o;
    logic [3:0]             min_mode_o;
    logic [3:0]             min_num_o;
    logic [`BIT_DEPTH+11:0] cost_o;
    logic                   done_o;

    intra_4x4_mode_sched #(.SATD_LAT(SATD_LAT)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .top_avail_i(top_avail_i),
        .left_avail_i(left_avail_i), .lambda_i(lambda_i), .pred_mode_i(pred_mode_i),
        .satd_i(satd_i), .rec_done_i(rec_done_i), .blk_num_o(blk_num_o), .mode_o(mode_o),
        .mode_val_o(mode_val_o), .min_val_o(min_val_o), .min_mode_o(min_mode_o),
        .min_num_o(min_num_o), .cost_o(cost_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    typedef struct { int mode; int blk; bit first; } issue_t;
    typedef struct { int mode; int blk; } dec_t;
    typedef struct { int due; int mode; } satd_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    issue_t expIssueQ[$];
    dec_t   expDecQ[$];
    satd_t  satdQ[$];
    int     satdTab[9];
    int     expTotal = 0;
    bit     mbActive = 0;
    int     gateCycle = 0;
    int     recDelay = 3;
    bit     decoy = 0;
    int     recCnt = 0;
    int     lastIssue = 0;
    int     lastMode = 0;
    int     lastMinMode = 0;
    int     lastMinNum = 0;
    int     doneCount = 0;
    bit     firstDecSeen = 0;
    int     firstDecMode = 0;
    int     issuesPerBlk[16];
    int     mvDelayBlk3 = 0;
    issue_t ie;
    dec_t   dd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit top, input bit left, input int lambda, input int pred);
        top_avail_i  = top;
        left_avail_i = left;
        lambda_i     = 7'(lambda);
        pred_mode_i  = 4'(pred);
    endtask

    task automatic setSatd(input int all);
        for (int m = 0; m < 9; m++) satdTab[m] = all;
    endtask

    // Expected issue order and decisions for a whole MB, straight from the availability rules.
    task automatic buildModel(input bit top, input bit left, input int lambda, input int pred);
        int x, y, best, bestMode, c;
        bit topOk, leftOk, ok, first;
        expIssueQ.delete();
        expDecQ.delete();
        expTotal = 0;
        for (int b = 0; b < 16; b++) begin
            x = ((b >> 2) & 1) * 2 + (b & 1);
            y = ((b >> 3) & 1) * 2 + ((b >> 1) & 1);
            topOk = (y != 0) || top;
            leftOk = (x != 0) || left;
            first = 1;
            best = -1;
            bestMode = 0;
            for (int m = 0; m < 9; m++) begin
                case (m)
                    2:       ok = 1;
                    0, 3, 7: ok = topOk;
                    1, 8:    ok = leftOk;
                    default: ok = topOk && leftOk;
                endcase
`ifdef I4X4_FAST_MODE_EN
                if (m > 2) ok = 0;
`endif
                if (ok) begin
                    expIssueQ.push_back('{m, b, first});
                    first = 0;
                    c = satdTab[m] + ((m == pred) ? 0 : 4 * lambda);
                    if (best < 0 || c < best) begin
                        best = c;
                        bestMode = m;
                    end
                end
            end
            expDecQ.push_back('{bestMode, b});
            expTotal += best;
            if (expTotal > COST_MAX) expTotal = COST_MAX;
        end
    endtask

    // SATD responder: answers each issued mode SATD_LAT cycles later, junk otherwise.
    initial begin
        satd_i = '0;
        forever begin
            @(negedge clk);
            if (rst) satdQ.delete();
            else if (mode_val_o) satdQ.push_back('{cyc + SATD_LAT, int'(mode_o)});
            if (satdQ.size() > 0 && satdQ[0].due == cyc) begin
                satd_i = (`BIT_DEPTH+8)'(satdTab[satdQ[0].mode]);
                void'(satdQ.pop_front());
            end else begin
                satd_i = (`BIT_DEPTH+8)'($urandom_range(0, 3));
            end
        end
    end

    // Reconstruction responder, optionally with a decoy pulse in the decision cycle.
    initial begin
        rec_done_i = 1'b0;
        forever begin
            @(negedge clk);
            rec_done_i = 1'b0;
            if (rst) recCnt = 0;
            else if (recCnt > 0) begin
                recCnt--;
                if (recCnt == 0) rec_done_i = 1'b1;
            end
            if (!rst && min_val_o) begin
                recCnt = recDelay;
                if (decoy) rec_done_i = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            expIssueQ.delete();
            expDecQ.delete();
            mbActive = 0;
            lastMode = 0;
            lastMinMode = 0;
            lastMinNum = 0;
        end else begin
            if (mode_val_o) begin
                if (expIssueQ.size() == 0) checkOutput("unexpected mode_val_o", 1, 0);
                else begin
                    ie = expIssueQ.pop_front();
                    checkOutput("mode_o", mode_o, ie.mode);
                    checkOutput("issue blk_num_o", blk_num_o, ie.blk);
                    if (ie.first) checkOutput("first issue after start/rec_done", cyc > gateCycle, 1);
                    else checkOutput("issue back-to-back", cyc, lastIssue + 1);
                    issuesPerBlk[ie.blk]++;
                end
                lastIssue = cyc;
                lastMode = mode_o;
            end else begin
                checkOutput("mode_o hold", mode_o, lastMode);
            end
            if (min_val_o) begin
                if (expDecQ.size() == 0) checkOutput("unexpected min_val_o", 1, 0);
                else begin
                    dd = expDecQ.pop_front();
                    checkOutput("min_mode_o", min_mode_o, dd.mode);
                    checkOutput("min_num_o", min_num_o, dd.blk);
                    checkOutput("min_val_o latency", cyc - lastIssue, SATD_LAT + 1);
                    if (!firstDecSeen) begin
                        firstDecSeen = 1;
                        firstDecMode = min_mode_o;
                    end
                    if (dd.blk == 3) mvDelayBlk3 = cyc - lastIssue;
                    gateCycle = cyc + recDelay;
                end
                lastMinMode = min_mode_o;
                lastMinNum = min_num_o;
            end else begin
                checkOutput("min_mode_o hold", min_mode_o, lastMinMode);
                checkOutput("min_num_o hold", min_num_o, lastMinNum);
            end
            if (done_o) begin
                doneCount++;
                checkOutput("done_o expected", mbActive && expDecQ.size() == 0 && expIssueQ.size() == 0, 1);
                checkOutput("cost_o at done", cost_o, expTotal);
                mbActive = 0;
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " blk_num_o"}, blk_num_o, 0);
        checkOutput({tag, " mode_o"}, mode_o, 0);
        checkOutput({tag, " mode_val_o"}, mode_val_o, 0);
        checkOutput({tag, " min_val_o"}, min_val_o, 0);
        checkOutput({tag, " min_mode_o"}, min_mode_o, 0);
        checkOutput({tag, " min_num_o"}, min_num_o, 0);
        checkOutput({tag, " cost_o"}, cost_o, 0);
        checkOutput({tag, " done_o"}, done_o, 0);
    endtask

    task automatic startMB(input bit top, input bit left, input int lambda, input int pred);
        @(negedge clk);
        applyStimulus(top, left, lambda, pred);
        buildModel(top, left, lambda, pred);
        firstDecSeen = 0;
        for (int b = 0; b < 16; b++) issuesPerBlk[b] = 0;
        mbActive = 1;
        gateCycle = cyc;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic waitDecision(input int blk);
        for (int k = 0; k < 3000 && !(min_val_o && min_num_o == 4'(blk)); k++) @(negedge clk);
        checkOutput("reach decision of block", (min_val_o && min_num_o == 4'(blk)) ? blk : -1, blk);
    endtask

    task automatic runMB(input bit top, input bit left, input int lambda, input int pred, input bit glitch);
        int n;
        n = doneCount;
        startMB(top, left, lambda, pred);
        if (glitch) begin
            waitDecision(2);
            start_i = 1'b1;
            @(negedge clk);
            start_i = 1'b0;
        end
        for (int k = 0; k < 4000 && doneCount == n; k++) @(negedge clk);
        checkOutput("done_o pulse count", doneCount - n, 1);
        @(negedge clk);
        checkOutput("done_o one cycle", done_o, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkResetOutputs("reset");

        // Corner block 0 gets only DC; block 3 sees all nine modes.
        setSatd(100);
        runMB(0, 0, 5, 2, 0);
        checkOutput("corner min_mode_o", firstDecMode, 2);
`ifdef I4X4_FAST_MODE_EN
        checkOutput("block 3 issue count", issuesPerBlk[3], 3);
`else
        checkOutput("block 3 issue count", issuesPerBlk[3], 9);
`endif
        checkOutput("block 3 decision delay", mvDelayBlk3, 3);
        checkOutput("corner MB cost_o", cost_o, 1600);

        setSatd(40);
        satdTab[4] = 50;
        runMB(1, 1, 3, 4, 0);
`ifdef I4X4_FAST_MODE_EN
        checkOutput("penalty min_mode_o", firstDecMode, 0);
        checkOutput("penalty MB cost_o", cost_o, 832);
`else
        checkOutput("penalty min_mode_o", firstDecMode, 4);
        checkOutput("penalty MB cost_o", cost_o, 800);
`endif

        setSatd(200);
        satdTab[0] = 10;
        satdTab[1] = 10;
        runMB(1, 1, 0, 15, 0);
        checkOutput("tie min_mode_o", firstDecMode, 0);
        checkOutput("tie MB cost_o", cost_o, 160);

        setSatd(1000);
        decoy = 1;
        runMB(1, 0, 0, 15, 1);
        decoy = 0;
        checkOutput("full MB cost_o", cost_o, 16000);

        // Abort in WAIT_REC of block 7.
        setSatd(1000);
        n = doneCount;
        startMB(1, 1, 0, 15);
        waitDecision(7);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkResetOutputs("abort");
        repeat (40) @(negedge clk);
        checkOutput("no done_o after abort", doneCount - n, 0);
        checkOutput("cost_o after abort", cost_o, 0);

        setSatd((1 << (`BIT_DEPTH + 8)) - 1);
        runMB(0, 0, 127, 15, 0);
        checkOutput("saturated cost_o", cost_o, COST_MAX);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
